// File: rtl/oldland_timer_pkg.sv
// Shared definitions for the oldland countdown timer.
// Register offsets, field positions and the bus FSM state type.
package oldland_timer_defs;

  localparam logic [2:0] REG_COUNT   = 3'd0;
  localparam logic [2:0] REG_RELOAD  = 3'd1;
  localparam logic [2:0] REG_CONTROL = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;

  localparam int CTRL_ENABLE       = 0;
  localparam int CTRL_PERIODIC     = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_PRESCALE_LSB = 16;

  localparam int STATUS_PENDING = 0;

  typedef enum logic {
    IDLE,
    RESP
  } bus_state_t;

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] cur,
    input logic [31:0] val,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/oldland_timer_prescale.sv
// Prescaler for the oldland timer.
// Emits one tick every prescale+1 enabled clocks.
module oldland_timer_prescale
  import oldland_timer_defs::*;
#(
  parameter int prescale_bits = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic [prescale_bits-1:0] prescale,
  output logic                     tick
);

  logic [prescale_bits-1:0] cnt_q;
  logic [prescale_bits-1:0] cnt_d;

  always_comb begin
    tick  = en && (cnt_q == prescale);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/oldland_timer.sv
// Memory-mapped 32-bit countdown timer with prescaler,
// one-shot/periodic modes and a level interrupt.
module oldland_timer
  import oldland_timer_defs::*;
#(
  parameter logic [31:0] reset_reload  = 32'h0,
  parameter int          prescale_bits = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        access,
  input  logic [2:0]  addr,
  input  logic [3:0]  bytesel,
  input  logic        wr_en,
  input  logic [31:0] wr_val,
  output logic [31:0] data,
  output logic        ack,
  output logic        error,
  output logic        irq
);

  localparam logic [31:0] CTRL_MASK =
    (32'hFFFF_FFFF >> (16 - prescale_bits)) & 32'hFFFF_0007;

  bus_state_t  state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;

  logic        wr_go, wr_count, wr_reload;
  logic        wr_ctrl, wr_status;
  logic [31:0] ctrl_wv;
  logic        periodic, expire;
  logic        ps_en, ps_clr, tick, kill, tick_eff;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = RESP;
          addr_d  = addr;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_go     = (state_q == IDLE) && access
                && wr_en && !addr[2];
    wr_count  = wr_go && (addr == REG_COUNT)
                && (bytesel != 4'b0);
    wr_reload = wr_go && (addr == REG_RELOAD)
                && (bytesel != 4'b0);
    wr_ctrl   = wr_go && (addr == REG_CONTROL)
                && (bytesel != 4'b0);
    wr_status = wr_go && (addr == REG_STATUS)
                && bytesel[0] && wr_val[0];
    ctrl_wv   = merge_lanes(ctrl_q, wr_val, bytesel)
                & CTRL_MASK;
    periodic  = ctrl_q[CTRL_PERIODIC];
    ps_en     = ctrl_q[CTRL_ENABLE]
                && ((count_q != 32'd0) || periodic);
    ps_clr    = wr_count || (wr_ctrl
                && !ctrl_q[CTRL_ENABLE]
                && ctrl_wv[CTRL_ENABLE]);
    // a COUNT write or a disabling CONTROL write beats a tick
    kill      = wr_count
                || (wr_ctrl && !ctrl_wv[CTRL_ENABLE]);
    tick_eff  = tick && !kill;
  end

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    expire    = 1'b0;
    if (tick_eff) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        expire  = 1'b1;
        count_d = periodic ? reload_q : 32'd0;
        if (!periodic) ctrl_d[CTRL_ENABLE] = 1'b0;
      end else if (periodic) begin
        count_d = reload_q;
      end
    end
    if (wr_count)
      count_d = merge_lanes(count_q, wr_val, bytesel);
    if (wr_reload)
      reload_d = merge_lanes(reload_q, wr_val, bytesel);
    if (wr_ctrl) ctrl_d = ctrl_wv;
    if (wr_status) pending_d = 1'b0;
    if (expire) pending_d = 1'b1;
    irq_d = pending_d && ctrl_d[CTRL_IRQ_EN];
  end

  oldland_timer_prescale #(
    .prescale_bits(prescale_bits)
  ) u_prescale (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ps_en),
    .clr     (ps_clr),
    .prescale(ctrl_q[CTRL_PRESCALE_LSB +: prescale_bits]),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 3'd0;
      count_q   <= 32'd0;
      reload_q  <= reset_reload;
      ctrl_q    <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    ack   = (state_q == RESP) && !addr_q[2];
    error = (state_q == RESP) && addr_q[2];
    irq   = irq_q;
    data  = 32'd0;
    if (ack) begin
      case (addr_q)
        REG_COUNT:   data = count_q;
        REG_RELOAD:  data = reload_q;
        REG_CONTROL: data = ctrl_q;
        REG_STATUS:  data[STATUS_PENDING] = pending_q;
        default:     data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_timer.sv
// Directed self-checking bench for oldland_timer.
module tb_oldland_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        access = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [3:0]  bytesel = 4'd0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_val = 32'd0;
  logic [31:0] data;
  logic        ack;
  logic        error;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  oldland_timer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .access (access),
    .addr   (addr),
    .bytesel(bytesel),
    .wr_en  (wr_en),
    .wr_val (wr_val),
    .data   (data),
    .ack    (ack),
    .error  (error),
    .irq    (irq)
  );

  task automatic bus(
    input  logic        we,
    input  logic [2:0]  a,
    input  logic [31:0] v,
    input  logic [3:0]  bs,
    output logic [31:0] d,
    output logic        ak,
    output logic        er
  );
    @(negedge clk);
    access = 1'b1; wr_en = we; addr = a;
    wr_val = v; bytesel = bs;
    ak = 1'b0; er = 1'b0; d = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack || error) begin
        ak = ack; er = error; d = data;
        break;
      end
    end
    access = 1'b0; wr_en = 1'b0;
    total++;
    if (!(ak || er)) begin
      bad++;
      $display("FAIL bus_timeout addr=%0d no ack/error", a);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic ak, er;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ack !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL rst_resp got ack=%b err=%b want 0 0",
               ack, error);
    end
    total++;
    if (irq !== 1'b0 || data !== 32'd0) begin
      bad++;
      $display("FAIL rst_out got irq=%b data=%h want 0 0",
               irq, data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    access = 1'b1; addr = 3'd0; wr_en = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b1 || data !== 32'd0) begin
      bad++;
      $display("FAIL latency got ack=%b data=%h want 1 0",
               ack, data);
    end
    access = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL ack_single got %b want 0", ack);
    end
    for (int a = 0; a < 4; a++) begin
      bus(1'b0, 3'(a), 32'd0, 4'd0, d, ak, er);
      total++;
      if (d !== 32'd0 || ak !== 1'b1 || er !== 1'b0
          || irq !== 1'b0) begin
        bad++;
        $display("FAIL rst_read%0d got d=%h ack=%b err=%b irq=%b want 0 1 0 0",
                 a, d, ak, er, irq);
      end
    end
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    logic ak, er;
    bus(1'b1, 3'd1, 32'd3, 4'hF, d, ak, er);
    bus(1'b1, 3'd0, 32'd3, 4'hF, d, ak, er);
    bus(1'b1, 3'd2, 32'd7, 4'hF, d, ak, er);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL per_irq0 got %b want 0", irq);
    end
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (irq !== 1'b0) begin
        bad++;
        $display("FAIL per_irq_early got %b want 0", irq);
      end
    end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL per_irq_rise got %b want 1", irq);
    end
    bus(1'b0, 3'd0, 32'd0, 4'd0, d, ak, er);
    total++;
    if (d !== 32'd2) begin
      bad++;
      $display("FAIL per_reload got %h want 2", d);
    end
    // this clear lands on the same edge as the next expiry
    bus(1'b1, 3'd3, 32'd1, 4'h1, d, ak, er);
    total++;
    if (d !== 32'd1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL set_wins got status=%h irq=%b want 1 1",
               d, irq);
    end
    bus(1'b1, 3'd3, 32'd1, 4'h1, d, ak, er);
    total++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL per_clear got status=%h irq=%b want 0 0",
               d, irq);
    end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL per_period got irq=%b want 1", irq);
    end
    bus(1'b1, 3'd2, 32'd0, 4'hF, d, ak, er);
    bus(1'b0, 3'd0, 32'd0, 4'd0, d, ak, er);
    total++;
    if (d !== 32'd3) begin
      bad++;
      $display("FAIL tick_discard got count=%h want 3", d);
    end
    bus(1'b1, 3'd3, 32'd1, 4'h1, d, ak, er);
    total++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL per_off got status=%h irq=%b want 0 0",
               d, irq);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] d;
    logic ak, er;
    bus(1'b1, 3'd0, 32'd2, 4'hF, d, ak, er);
    total++;
    if (d !== 32'd2) begin
      bad++;
      $display("FAIL os_count_wr got %h want 2", d);
    end
    bus(1'b1, 3'd2, 32'h0002_0005, 4'hF, d, ak, er);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL os_early got irq=%b want 0", irq);
    end
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL os_expire got irq=%b want 1", irq);
    end
    bus(1'b0, 3'd2, 32'd0, 4'd0, d, ak, er);
    total++;
    if (d !== 32'h0002_0004) begin
      bad++;
      $display("FAIL os_ctrl got %h want 00020004", d);
    end
    repeat (10) @(posedge clk);
    bus(1'b0, 3'd0, 32'd0, 4'd0, d, ak, er);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL os_count got %h want 0", d);
    end
    bus(1'b1, 3'd3, 32'd1, 4'h1, d, ak, er);
    bus(1'b1, 3'd2, 32'd0, 4'hF, d, ak, er);
  endtask

  task automatic test_byte_lanes;
    logic [31:0] d;
    logic ak, er;
    bus(1'b1, 3'd1, 32'hAABB_CCDD, 4'hF, d, ak, er);
    bus(1'b1, 3'd1, 32'h1122_3344, 4'b0101, d, ak, er);
    total++;
    if (d !== 32'hAA22_CC44) begin
      bad++;
      $display("FAIL lanes_wr got %h want aa22cc44", d);
    end
    bus(1'b1, 3'd1, 32'hFFFF_FFFF, 4'b0000, d, ak, er);
    total++;
    if (ak !== 1'b1 || d !== 32'hAA22_CC44) begin
      bad++;
      $display("FAIL lanes_none got ack=%b d=%h want 1 aa22cc44",
               ak, d);
    end
    bus(1'b1, 3'd2, 32'hFFFF_FFF8, 4'hF, d, ak, er);
    total++;
    if (d !== 32'hFFFF_0000) begin
      bad++;
      $display("FAIL ctrl_mask got %h want ffff0000", d);
    end
    bus(1'b1, 3'd2, 32'd0, 4'hF, d, ak, er);
  endtask

  task automatic test_error;
    logic [31:0] d;
    logic ak, er;
    bus(1'b0, 3'd5, 32'd0, 4'd0, d, ak, er);
    total++;
    if (er !== 1'b1 || ak !== 1'b0 || d !== 32'd0) begin
      bad++;
      $display("FAIL err_rd got err=%b ack=%b d=%h want 1 0 0",
               er, ak, d);
    end
    @(posedge clk); #1;
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL err_single got %b want 0", error);
    end
    bus(1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, d, ak, er);
    total++;
    if (er !== 1'b1 || ak !== 1'b0) begin
      bad++;
      $display("FAIL err_wr got err=%b ack=%b want 1 0", er, ak);
    end
    bus(1'b0, 3'd1, 32'd0, 4'd0, d, ak, er);
    total++;
    if (d !== 32'hAA22_CC44) begin
      bad++;
      $display("FAIL err_nochg got %h want aa22cc44", d);
    end
    bus(1'b0, 3'd0, 32'd0, 4'd0, d, ak, er);
    total++;
    if (ak !== 1'b1 || er !== 1'b0 || d !== 32'd0) begin
      bad++;
      $display("FAIL err_after got ack=%b err=%b d=%h want 1 0 0",
               ak, er, d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic ak, er;
    bus(1'b1, 3'd0, 32'd1, 4'hF, d, ak, er);
    bus(1'b1, 3'd2, 32'd5, 4'hF, d, ak, er);
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL mid_irq got %b want 1", irq);
    end
    @(negedge clk);
    access = 1'b1; addr = 3'd1; wr_en = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b1 || data !== 32'hAA22_CC44) begin
      bad++;
      $display("FAIL mid_ack got ack=%b d=%h want 1 aa22cc44",
               ack, data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ack !== 1'b0 || irq !== 1'b0 || data !== 32'd0) begin
      bad++;
      $display("FAIL mid_drop got ack=%b irq=%b d=%h want 0 0 0",
               ack, irq, data);
    end
    access = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus(1'b0, 3'(a), 32'd0, 4'd0, d, ak, er);
      total++;
      if (d !== 32'd0 || ak !== 1'b1) begin
        bad++;
        $display("FAIL mid_reg%0d got d=%h ack=%b want 0 1",
                 a, d, ak);
      end
    end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_oneshot;
    test_byte_lanes;
    test_error;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
